// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp32_pkg
// Brief   : Shared types and constants for the sequential binary32 multiplier
// Revision: 1.0 - initial release
// ============================================================================
package fp32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7fc00000;
    localparam int          FP32_BIAS = 127;
    localparam logic [7:0]  EXP_INF   = 8'hff;
    localparam int          MUL_STEPS = 24;

endpackage
`default_nettype wire

// File: rtl/fp32_unpack.sv
`default_nettype none
// ============================================================================
// Module  : fp32_unpack
// Brief   : Combinational operand decoder; classifies the operand and returns
//           a significand normalised so bit 23 is set (finite non-zero case)
// Revision: 1.0 - initial release
// ============================================================================
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       x,
    output logic              sign,
    output logic [23:0]       sig,
    output logic signed [9:0] exp_adj,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan,
    output logic              is_snan
);

    logic [7:0]  w_efield;
    logic [22:0] w_frac;
    logic [23:0] w_raw;
    logic [4:0]  w_lz;
    logic        w_found;

    assign w_efield = x[30:23];
    assign w_frac   = x[22:0];
    assign sign     = x[31];
    assign w_raw    = {(w_efield != 8'd0), w_frac};

    assign is_zero  = (w_efield == 8'd0)    && (w_frac == 23'd0);
    assign is_inf   = (w_efield == EXP_INF) && (w_frac == 23'd0);
    assign is_nan   = (w_efield == EXP_INF) && (w_frac != 23'd0);
    assign is_snan  = is_nan && !w_frac[22];

    // Leading-zero count of the raw significand; non-zero only for subnormals
    always_comb begin
        w_lz    = 5'd0;
        w_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!w_found && w_raw[i]) begin
                w_lz    = 5'(23 - i);
                w_found = 1'b1;
            end
        end
    end

    // Subnormals behave as exponent 1, then lose one per normalising shift
    assign sig     = w_raw << w_lz;
    assign exp_adj = ((w_efield == 8'd0) ? 10'sd1 : $signed({2'b00, w_efield}))
                     - $signed({5'b00000, w_lz});

endmodule
`default_nettype wire

// File: rtl/fp32_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : fp32_mul_seq
// Brief   : Sequential IEEE-754 binary32 multiplier, radix-2 shift-add core,
//           round-to-nearest-even, full exception flags, valid/ready handshake
// Revision: 1.0 - initial release
// ============================================================================
module fp32_mul_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        exc_invalid,
    output logic        exc_overflow,
    output logic        exc_underflow,
    output logic        exc_inexact,
    output logic        busy
);

    localparam logic signed [9:0] c_bias = 10'(FP32_BIAS);

    state_t            r_state, w_next;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_mcand, r_mplier;
    logic [47:0]       r_prod;
    logic [4:0]        r_cnt;
    logic [31:0]       r_y;
    logic              r_inv, r_ovf, r_unf, r_inx;

    logic              ua_sign, ub_sign;
    logic [23:0]       ua_sig, ub_sig;
    logic signed [9:0] ua_exp, ub_exp;
    logic              ua_zero, ua_inf, ua_nan, ua_snan;
    logic              ub_zero, ub_inf, ub_nan, ub_snan;

    logic              w_sign, w_special, w_spec_inv;
    logic [31:0]       w_spec_y;

    logic [47:0]       w_pn, w_shifted;
    logic signed [9:0] w_e, w_e_fin, w_sh_full;
    logic [4:0]        w_sh;
    logic              w_tiny, w_lost, w_g, w_s, w_inc;
    logic [23:0]       w_m;
    logic [24:0]       w_m_rnd;
    logic [31:0]       w_rnd_y;
    logic              w_rnd_ovf, w_rnd_unf, w_rnd_inx;

    fp32_unpack u_unpack_a (
        .x(a), .sign(ua_sign), .sig(ua_sig), .exp_adj(ua_exp),
        .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan), .is_snan(ua_snan)
    );

    fp32_unpack u_unpack_b (
        .x(b), .sign(ub_sign), .sig(ub_sig), .exp_adj(ub_exp),
        .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan), .is_snan(ub_snan)
    );

    assign w_sign    = ua_sign ^ ub_sign;
    assign w_special = ua_zero | ua_inf | ua_nan | ub_zero | ub_inf | ub_nan;

    // Result for operands that bypass the multiplier; a's NaN wins over b's
    always_comb begin
        w_spec_y   = {w_sign, 31'd0};
        w_spec_inv = 1'b0;
        if (ua_nan) begin
            w_spec_y   = {a[31], EXP_INF, 1'b1, a[21:0]};
            w_spec_inv = ua_snan;
        end else if (ub_nan) begin
            w_spec_y   = {b[31], EXP_INF, 1'b1, b[21:0]};
            w_spec_inv = ub_snan;
        end else if ((ua_inf && ub_zero) || (ua_zero && ub_inf)) begin
            w_spec_y   = FP32_QNAN;
            w_spec_inv = 1'b1;
        end else if (ua_inf || ub_inf) begin
            w_spec_y   = {w_sign, EXP_INF, 23'd0};
        end
    end

    // Normalise, denormalise when tiny, then round the product to nearest even
    always_comb begin
        w_pn      = r_prod[47] ? r_prod : (r_prod << 1);
        w_e       = r_exp + (r_prod[47] ? 10'sd1 : 10'sd0);
        w_tiny    = (w_e <= 10'sd0);
        w_sh_full = 10'sd1 - w_e;
        w_sh      = 5'd0;
        w_shifted = w_pn;
        w_lost    = 1'b0;
        if (w_tiny) begin
            w_sh      = (w_sh_full > 10'sd26) ? 5'd26 : w_sh_full[4:0];
            w_shifted = w_pn >> w_sh;
            w_lost    = |(w_pn & ~({48{1'b1}} << w_sh));
        end
        w_m       = w_shifted[47:24];
        w_g       = w_shifted[23];
        w_s       = (|w_shifted[22:0]) | w_lost;
        w_inc     = w_g & (w_s | w_m[0]);
        w_m_rnd   = {1'b0, w_m} + {24'd0, w_inc};
        w_rnd_inx = w_g | w_s;
        w_rnd_ovf = 1'b0;
        w_rnd_unf = 1'b0;
        w_e_fin   = w_e + (w_m_rnd[24] ? 10'sd1 : 10'sd0);
        if (w_tiny) begin
            // A carry into bit 23 lands in the exponent LSB, giving exponent 1
            w_rnd_y   = {r_sign, 7'd0, w_m_rnd[23:0]};
            w_rnd_unf = w_rnd_inx;
        end else if (w_e_fin > 10'sd254) begin
            w_rnd_y   = {r_sign, EXP_INF, 23'd0};
            w_rnd_ovf = 1'b1;
            w_rnd_inx = 1'b1;
        end else begin
            w_rnd_y   = {r_sign, w_e_fin[7:0], (w_m_rnd[24] ? 23'd0 : w_m_rnd[22:0])};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = w_special ? DONE : MUL;
            end
            MUL:  if (r_cnt == 5'd0) w_next = RND;
            RND:  w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, shift-add iterations and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_mcand  <= 24'd0;
            r_mplier <= 24'd0;
            r_prod   <= 48'd0;
            r_cnt    <= 5'd0;
            r_y      <= 32'd0;
            r_inv    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign   <= w_sign;
                    r_exp    <= ua_exp + ub_exp - c_bias;
                    r_mcand  <= ua_sig;
                    r_mplier <= ub_sig;
                    r_prod   <= 48'd0;
                    r_cnt    <= 5'(MUL_STEPS - 1);
                    if (w_special) begin
                        r_y   <= w_spec_y;
                        r_inv <= w_spec_inv;
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                        r_inx <= 1'b0;
                    end
                end
                MUL: begin
                    // Multiplier scanned MSB first: shift partial product, add
                    r_prod <= (r_prod << 1) + (r_mplier[r_cnt] ? {24'd0, r_mcand} : 48'd0);
                    r_cnt  <= r_cnt - 5'd1;
                end
                RND: begin
                    r_y   <= w_rnd_y;
                    r_inv <= 1'b0;
                    r_ovf <= w_rnd_ovf;
                    r_unf <= w_rnd_unf;
                    r_inx <= w_rnd_inx;
                end
                default: ;
            endcase
        end
    end

    assign y             = r_y;
    assign exc_invalid   = r_inv;
    assign exc_overflow  = r_ovf;
    assign exc_underflow = r_unf;
    assign exc_inexact   = r_inx;

endmodule
`default_nettype wire
